rect_loader: RTL and testbench

Per-frame rectangle descriptor fetcher for the GPU. On a `start` pulse (issued at vblank), it reads `RECT_COUNT` descriptor records from video memory over a 1-cycle-latency synchronous read port. It converts each record from origin/size form into the edge form `left`/`top`/`right`/`bottom` used by the per-pixel point-in-rect comparators. Each converted rectangle is written into the GPU's rect table, one write strobe per rectangle.

---
 rtl/rect_loader_pkg.sv | 20 ++
 rtl/rect_loader_edge_adder.sv | 16 +
 rtl/rect_loader.sv | 215 +++++++++++++++++++++
 tb/tb_rect_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rect_loader_pkg.sv
// Shared definitions for the rectangle descriptor loader: FSM states and
// the layout of one descriptor record in video memory.
package rect_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT
    } rect_state_t;

    localparam int RECT_WORDS = 5;

    localparam logic [2:0] OFF_X     = 3'd0;
    localparam logic [2:0] OFF_Y     = 3'd1;
    localparam logic [2:0] OFF_W     = 3'd2;
    localparam logic [2:0] OFF_H     = 3'd3;
    localparam logic [2:0] OFF_COLOR = 3'd4;

endpackage

// File: rtl/rect_loader_edge_adder.sv
// Saturating unsigned add used to turn origin + extent into a far edge;
// an overflowing sum clamps to all-ones instead of wrapping.
module edge_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];

endmodule

// File: rtl/rect_loader.sv
// Per-frame rectangle descriptor fetcher: reads origin/size records from
// video memory and writes edge-form entries into the GPU rect table.
`ifndef COORD_WIDTH
`define COORD_WIDTH 16
`endif

module rect_loader
    import rect_loader_pkg::*;
#(
    parameter int COORD_WIDTH = `COORD_WIDTH,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int RECT_COUNT  = 64,
    parameter int BASE_ADDR   = 0,
    parameter int IDX_WIDTH   = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic                   tbl_we,
    output logic [IDX_WIDTH-1:0]   tbl_idx,
    output logic [COORD_WIDTH-1:0] tbl_left,
    output logic [COORD_WIDTH-1:0] tbl_top,
    output logic [COORD_WIDTH-1:0] tbl_right,
    output logic [COORD_WIDTH-1:0] tbl_bottom,
    output logic [DATA_WIDTH-1:0]  tbl_color
);

    localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(RECT_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(RECT_WORDS);

    rect_state_t            state;
    rect_state_t            state_next;
    logic [2:0]             word;
    logic [2:0]             word_next;
    logic [IDX_WIDTH-1:0]   idx;
    logic [IDX_WIDTH-1:0]   idx_next;
    logic [ADDR_WIDTH-1:0]  rect_base;
    logic [ADDR_WIDTH-1:0]  rect_base_next;

    logic                   rd_en_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [2:0]             tag_d;
    logic                   we_d;
    logic                   last;

    logic [2:0]             rd_tag;
    logic                   pend_valid;
    logic [2:0]             pend_tag;

    logic [COORD_WIDTH-1:0] coord;
    logic [COORD_WIDTH-1:0] x_q;
    logic [COORD_WIDTH-1:0] y_q;
    logic [COORD_WIDTH-1:0] w_q;
    logic [COORD_WIDTH-1:0] h_q;
    logic [COORD_WIDTH-1:0] right_sum;
    logic [COORD_WIDTH-1:0] bottom_sum;

    assign last  = (idx == LAST_IDX);
    assign coord = mem_rdata[COORD_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            word      <= '0;
            idx       <= '0;
            rect_base <= '0;
        end else begin
            state     <= state_next;
            word      <= word_next;
            idx       <= idx_next;
            rect_base <= rect_base_next;
        end
    end

    // The FSM runs one cycle ahead of the registered outputs. EMIT of a
    // non-final rectangle also issues word 0 of the next one, which keeps
    // the period at six cycles.
    always_comb begin
        state_next     = state;
        word_next      = word;
        idx_next       = idx;
        rect_base_next = rect_base;
        rd_en_d        = 1'b0;
        addr_d         = mem_addr;
        tag_d          = rd_tag;
        we_d           = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_FETCH;
                    word_next      = OFF_X;
                    idx_next       = '0;
                    rect_base_next = BASE;
                end
            end
            ST_FETCH: begin
                rd_en_d = 1'b1;
                addr_d  = rect_base + ADDR_WIDTH'(word);
                tag_d   = word;
                if (word == OFF_COLOR) begin
                    state_next = ST_WAIT;
                end else begin
                    word_next = word + 3'd1;
                end
            end
            ST_WAIT: begin
                state_next = ST_EMIT;
            end
            ST_EMIT: begin
                we_d = 1'b1;
                if (last) begin
                    state_next = ST_IDLE;
                end else begin
                    rd_en_d        = 1'b1;
                    addr_d         = rect_base + STRIDE;
                    tag_d          = OFF_X;
                    rect_base_next = rect_base + STRIDE;
                    idx_next       = idx + IDX_WIDTH'(1);
                    word_next      = OFF_Y;
                    state_next     = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            rd_tag     <= '0;
            pend_valid <= 1'b0;
            pend_tag   <= '0;
        end else begin
            busy       <= (state != ST_IDLE);
            mem_rd_en  <= rd_en_d;
            mem_addr   <= addr_d;
            rd_tag     <= tag_d;
            pend_valid <= mem_rd_en;
            pend_tag   <= rd_tag;
        end
    end

    // Read data arrives one cycle after its address; the delayed tag says
    // which field it belongs to. Color is taken directly at emit time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
            w_q <= '0;
            h_q <= '0;
        end else if (pend_valid) begin
            case (pend_tag)
                OFF_X:   x_q <= coord;
                OFF_Y:   y_q <= coord;
                OFF_W:   w_q <= coord;
                OFF_H:   h_q <= coord;
                default: ;
            endcase
        end
    end

    edge_adder #(
        .WIDTH (COORD_WIDTH)
    ) u_right_edge (
        .a   (x_q),
        .b   (w_q),
        .sum (right_sum)
    );

    edge_adder #(
        .WIDTH (COORD_WIDTH)
    ) u_bottom_edge (
        .a   (y_q),
        .b   (h_q),
        .sum (bottom_sum)
    );

    // Done follows the final table write by one cycle, when busy has dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_we     <= 1'b0;
            tbl_idx    <= '0;
            tbl_left   <= '0;
            tbl_top    <= '0;
            tbl_right  <= '0;
            tbl_bottom <= '0;
            tbl_color  <= '0;
            done       <= 1'b0;
        end else begin
            tbl_we <= we_d;
            done   <= tbl_we && (tbl_idx == LAST_IDX);
            if (we_d) begin
                tbl_idx    <= idx;
                tbl_left   <= x_q;
                tbl_top    <= y_q;
                tbl_right  <= right_sum;
                tbl_bottom <= bottom_sum;
                tbl_color  <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rect_loader.sv
// Scoreboard bench for rect_loader: stimulus pushes expected reads, table
// writes and done pulses; a negedge monitor pops and compares them.
module tb_rect_loader;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
    } rd_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [15:0] l;
        logic [15:0] t;
        logic [15:0] r;
        logic [15:0] b;
        logic [15:0] c;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0;
    logic        tbl_we;
    logic [1:0]  tbl_idx;
    logic [15:0] tbl_left;
    logic [15:0] tbl_top;
    logic [15:0] tbl_right;
    logic [15:0] tbl_bottom;
    logic [15:0] tbl_color;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  done_q[$];
    rd_t rd_e;
    wr_t wr_e;
    int  done_e;

    // Three records at 0x100: plain, unit-size at origin, saturating/zero-height.
    logic [15:0] mem [0:15] = '{
        16'd10, 16'd20, 16'd30, 16'd40, 16'hF00F,
        16'd0,  16'd0,  16'd1,  16'd1,  16'h0001,
        16'hFFF0, 16'd5, 16'h0020, 16'd0, 16'hABCD,
        16'hDEAD
    };
    logic [15:0] mem_off;

    // Hand-computed edge-form results for the three records.
    logic [15:0] exp_left   [0:2] = '{16'd10, 16'd0, 16'hFFF0};
    logic [15:0] exp_top    [0:2] = '{16'd20, 16'd0, 16'd5};
    logic [15:0] exp_right  [0:2] = '{16'd40, 16'd1, 16'hFFFF};
    logic [15:0] exp_bottom [0:2] = '{16'd60, 16'd1, 16'd5};
    logic [15:0] exp_color  [0:2] = '{16'hF00F, 16'h0001, 16'hABCD};

    rect_loader #(
        .COORD_WIDTH (16),
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (16),
        .RECT_COUNT  (3),
        .BASE_ADDR   (16'h100)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tbl_we     (tbl_we),
        .tbl_idx    (tbl_idx),
        .tbl_left   (tbl_left),
        .tbl_top    (tbl_top),
        .tbl_right  (tbl_right),
        .tbl_bottom (tbl_bottom),
        .tbl_color  (tbl_color)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    assign mem_off = mem_addr - 16'h100;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= (mem_off < 16'd15) ? mem[mem_off[3:0]] : 16'hDEAD;
        end
    end

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, got, exp);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [63:0] got);
        checks++;
        failures++;
        $display("[TB] FAIL unexpected %s at cycle %0d: got %0h expected none", name, cycle, got);
    endtask

    task automatic push_load(input int t0);
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 5; k++) begin
                rd_q.push_back('{cyc: t0 + 1 + 6 * i + k, addr: 16'(16'h100 + 5 * i + k)});
            end
            wr_q.push_back('{cyc: t0 + 7 + 6 * i, idx: i, l: exp_left[i], t: exp_top[i],
                             r: exp_right[i], b: exp_bottom[i], c: exp_color[i]});
        end
        done_q.push_back(t0 + 20);
    endtask

    // Drive a one-cycle start so that it is sampled at edge 'target'.
    task automatic apply_stimulus(input int target);
        while (cycle < target - 1) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"},   64'(busy),       64'd0);
        check_output({tag, "_done"},   64'(done),       64'd0);
        check_output({tag, "_rd_en"},  64'(mem_rd_en),  64'd0);
        check_output({tag, "_addr"},   64'(mem_addr),   64'd0);
        check_output({tag, "_we"},     64'(tbl_we),     64'd0);
        check_output({tag, "_idx"},    64'(tbl_idx),    64'd0);
        check_output({tag, "_left"},   64'(tbl_left),   64'd0);
        check_output({tag, "_top"},    64'(tbl_top),    64'd0);
        check_output({tag, "_right"},  64'(tbl_right),  64'd0);
        check_output({tag, "_bottom"}, 64'(tbl_bottom), 64'd0);
        check_output({tag, "_color"},  64'(tbl_color),  64'd0);
    endtask

    // Monitor: every strobe the DUT presents must match the queue head.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_rd_en) begin
                if (rd_q.size() == 0) begin
                    report_unexpected("read", 64'(mem_addr));
                end else begin
                    rd_e = rd_q.pop_front();
                    check_output("rd_cycle", 64'(cycle), 64'(rd_e.cyc));
                    check_output("rd_addr", 64'(mem_addr), 64'(rd_e.addr));
                    check_output("rd_busy", 64'(busy), 64'd1);
                end
            end
            if (tbl_we) begin
                if (wr_q.size() == 0) begin
                    report_unexpected("write", 64'(tbl_idx));
                end else begin
                    wr_e = wr_q.pop_front();
                    check_output("wr_cycle",  64'(cycle),      64'(wr_e.cyc));
                    check_output("wr_idx",    64'(tbl_idx),    64'(wr_e.idx));
                    check_output("wr_left",   64'(tbl_left),   64'(wr_e.l));
                    check_output("wr_top",    64'(tbl_top),    64'(wr_e.t));
                    check_output("wr_right",  64'(tbl_right),  64'(wr_e.r));
                    check_output("wr_bottom", 64'(tbl_bottom), 64'(wr_e.b));
                    check_output("wr_color",  64'(tbl_color),  64'(wr_e.c));
                    check_output("wr_busy",   64'(busy),       64'd1);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    report_unexpected("done", 64'(cycle));
                end else begin
                    done_e = done_q.pop_front();
                    check_output("done_cycle", 64'(cycle), 64'(done_e));
                    check_output("done_busy", 64'(busy), 64'd0);
                end
            end
        end
    end

    initial begin
        int t0;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        // Load A with an ignored start at cycle 4, then a start on A's done cycle.
        $display("[TB] load with mid-load start and back-to-back reload");
        t0 = cycle + 2;
        push_load(t0);
        apply_stimulus(t0);
        apply_stimulus(t0 + 4);
        t0 = t0 + 20;
        push_load(t0);
        apply_stimulus(t0);
        while (cycle < t0 + 24) @(negedge clk);

        // Load aborted by reset at cycle 9, released at cycle 12.
        $display("[TB] reset mid-load");
        t0 = cycle + 2;
        push_load(t0);
        apply_stimulus(t0);
        while (cycle < t0 + 8) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        repeat (3) begin
            @(negedge clk);
            check_all_zero("in_reset");
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_all_zero("after_reset");
        end

        $display("[TB] reload after reset");
        t0 = cycle + 2;
        push_load(t0);
        apply_stimulus(t0);
        while (cycle < t0 + 24) @(negedge clk);

        check_output("rd_queue_empty",   64'(rd_q.size()),   64'd0);
        check_output("wr_queue_empty",   64'(wr_q.size()),   64'd0);
        check_output("done_queue_empty", 64'(done_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
